// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FUNCT codes and FSM states.
package mult_div_unit_pkg;

  localparam int unsigned FunctW = 6;

  localparam logic [FunctW-1:0] FunctMult  = 6'b011000;
  localparam logic [FunctW-1:0] FunctMultu = 6'b011001;
  localparam logic [FunctW-1:0] FunctDiv   = 6'b011010;
  localparam logic [FunctW-1:0] FunctDivu  = 6'b011011;

  typedef enum logic [1:0] {
    MduIdle = 2'b00,
    MduMul  = 2'b01,
    MduDiv  = 2'b10,
    MduDone = 2'b11
  } mdu_state_e;

  function automatic logic is_mdu_funct(logic [FunctW-1:0] f);
    return (f == FunctMult) || (f == FunctMultu) || (f == FunctDiv) || (f == FunctDivu);
  endfunction

  function automatic logic is_signed_funct(logic [FunctW-1:0] f);
    return (f == FunctMult) || (f == FunctDiv);
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Restoring shift-subtract divider on unsigned magnitudes, one quotient bit per step.
module mdu_divider #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             init_i,
  input  logic             step_i,
  input  logic [Width-1:0] dividend_i,
  input  logic [Width-1:0] divisor_i,
  output logic [Width-1:0] quotient_o,
  output logic [Width-1:0] remainder_o
);

  logic [Width:0]   rem_q, rem_d;
  logic [Width-1:0] quo_q, quo_d;
  logic [Width-1:0] dvs_q;
  logic [Width:0]   shifted;
  logic [Width:0]   diff;
  logic             fits;

  always_comb begin
    shifted = {rem_q[Width-1:0], quo_q[Width-1]};
    diff    = shifted - {1'b0, dvs_q};
    // A set carry-out from the previous shift means the subtraction always fits.
    fits    = rem_q[Width] | ~diff[Width];
    rem_d   = fits ? diff : shifted;
    quo_d   = {quo_q[Width-2:0], fits};
  end

  // Next-step values let the owner capture the final result on the last step edge.
  assign quotient_o  = quo_d;
  assign remainder_o = rem_d[Width-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (init_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
    end else if (step_i) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multi-cycle MULT/MULTU/DIV/DIVU unit; busy stalls the pipe, done pulses with {hi, lo}.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [FunctW-1:0] funct,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result_hi,
  output logic [DATA_W-1:0] result_lo
);

  localparam int unsigned CntW = $clog2(DATA_W);
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

  mdu_state_e          state_q;
  logic [CntW-1:0]     cnt_q;
  logic                busy_q, done_q;
  logic [DATA_W-1:0]   result_hi_q, result_lo_q;
  logic [2*DATA_W-1:0] prod_q, prod_d;
  logic [DATA_W-1:0]   mcand_q;
  logic                neg_res_q, neg_rem_q, div_zero_q;

  logic              op_signed, op_is_div, accept, last_step;
  logic              a_neg, b_neg;
  logic [DATA_W-1:0] abs_a, abs_b;
  logic [DATA_W:0]   add_sum;
  logic [2*DATA_W-1:0] mul_res;
  logic [DATA_W-1:0] div_q, div_r, quo_fix, rem_fix;

  always_comb begin
    op_signed = is_signed_funct(funct);
    op_is_div = (funct == FunctDiv) || (funct == FunctDivu);
    accept    = ((state_q == MduIdle) || (state_q == MduDone)) && start && !flush &&
                is_mdu_funct(funct);
    a_neg     = op_signed & operand_a[DATA_W-1];
    b_neg     = op_signed & operand_b[DATA_W-1];
    abs_a     = a_neg ? -operand_a : operand_a;
    abs_b     = b_neg ? -operand_b : operand_b;
    last_step = (cnt_q == LastCnt);
  end

  // Shift-add: multiplier sits in the low half and drains out as the product fills in.
  always_comb begin
    add_sum = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + {1'b0, (prod_q[0] ? mcand_q : '0)};
    prod_d  = {add_sum, prod_q[DATA_W-1:1]};
    mul_res = neg_res_q ? -prod_d : prod_d;
  end

  mdu_divider #(
    .Width (DATA_W)
  ) u_divider (
    .clk_i       (clk),
    .rst_i       (rst),
    .init_i      (accept && op_is_div),
    .step_i      (state_q == MduDiv),
    .dividend_i  (abs_a),
    .divisor_i   (abs_b),
    .quotient_o  (div_q),
    .remainder_o (div_r)
  );

  // Divide by zero: quotient all ones; remainder already reproduces the dividend.
  always_comb begin
    quo_fix = div_zero_q ? '1 : (neg_res_q ? -div_q : div_q);
    rem_fix = neg_rem_q ? -div_r : div_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MduIdle;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_hi_q <= '0;
      result_lo_q <= '0;
      prod_q      <= '0;
      mcand_q     <= '0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        MduIdle, MduDone: begin
          if (accept) begin
            state_q    <= op_is_div ? MduDiv : MduMul;
            busy_q     <= 1'b1;
            cnt_q      <= '0;
            prod_q     <= {{DATA_W{1'b0}}, abs_b};
            mcand_q    <= abs_a;
            neg_res_q  <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            div_zero_q <= (operand_b == '0);
          end else begin
            state_q <= MduIdle;
            busy_q  <= 1'b0;
          end
        end
        MduMul, MduDiv: begin
          if (flush) begin
            state_q <= MduIdle;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
            if (state_q == MduMul) begin
              prod_q <= prod_d;
            end
            if (last_step) begin
              state_q <= MduDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              if (state_q == MduMul) begin
                result_hi_q <= mul_res[2*DATA_W-1:DATA_W];
                result_lo_q <= mul_res[DATA_W-1:0];
              end else begin
                result_hi_q <= rem_fix;
                result_lo_q <= quo_fix;
              end
            end
          end
        end
        default: begin
          state_q <= MduIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result_hi = result_hi_q;
  assign result_lo = result_lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model checked every cycle plus literal vectors.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [5:0]  funct;
  logic [31:0] operand_a, operand_b;
  logic        busy, done;
  logic [31:0] result_hi, result_lo;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [5:0] FMult  = 6'b011000;
  localparam logic [5:0] FMultu = 6'b011001;
  localparam logic [5:0] FDiv   = 6'b011010;
  localparam logic [5:0] FDivu  = 6'b011011;
  localparam logic [5:0] FAddu  = 6'b100001;

  always #5 clk = ~clk;

  mult_div_unit #(
    .DATA_W (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .funct     (funct),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .result_hi (result_hi),
    .result_lo (result_lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Plain-arithmetic reference: {hi, lo} for one operation.
  function automatic logic [63:0] ref_result(logic [5:0] f, logic [31:0] a, logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint q;
    longint r;
    logic [63:0] p;
    case (f)
      FMult:  begin p = 64'(sa * sb); return p; end
      FMultu: return {32'b0, a} * {32'b0, b};
      FDiv: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      FDivu: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: return 64'b0;
    endcase
  endfunction

  function automatic logic is_op(logic [5:0] f);
    return (f == FMult) || (f == FMultu) || (f == FDiv) || (f == FDivu);
  endfunction

  // Timing model: 32 busy cycles after acceptance, then a one-cycle done with the result.
  int          m_remain = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_pend = '0;
  logic        m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_remain <= 0;
      m_done   <= 1'b0;
      m_hi     <= '0;
      m_lo     <= '0;
      m_valid  <= 1'b1;
    end else begin
      m_done <= 1'b0;
      if (m_remain > 0) begin
        if (flush) begin
          m_remain <= 0;
        end else begin
          m_remain <= m_remain - 1;
          if (m_remain == 1) begin
            m_done <= 1'b1;
            {m_hi, m_lo} <= m_pend;
          end
        end
      end else if (start && !flush && is_op(funct)) begin
        m_pend   <= ref_result(funct, operand_a, operand_b);
        m_remain <= 32;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc busy", {63'b0, busy}, {63'b0, (m_remain > 0)});
      check("cyc done", {63'b0, done}, {63'b0, m_done});
      check("cyc result", {result_hi, result_lo}, {m_hi, m_lo});
    end
  end

  // Starts in the current cycle; optionally pokes a second start mid-operation.
  task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input bit poke);
    int lat;
    int nbusy;
    funct = f; operand_a = a; operand_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    nbusy = 0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      if (poke && lat == 5) begin
        start = 1'b1; funct = FDivu; operand_a = ~a; operand_b = 32'd3;
      end else if (poke && lat == 6) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'd33);
    check({name, " busy cycles"}, 64'(nbusy), 64'd32);
    check({name, " result"}, {result_hi, result_lo}, {ehi, elo});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit saw_done;
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct = '0; operand_a = '0; operand_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset outputs", {30'b0, busy, done, result_hi, result_lo}, 64'd0);

    run_op("mult -3*5", FMult, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    run_op("multu max", FMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("divu 100/7 b2b", FDivu, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 1'b0);
    run_op("div -7/2", FDiv, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1);
    run_op("div min/-1", FDiv, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run_op("divu by zero", FDivu, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF, 1'b0);
    run_op("div neg by zero", FDiv, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0);
    run_op("mult neg*neg", FMult, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006, 1'b0);
    run_op("div 7/-2", FDiv, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    @(posedge clk); #1;

    // Flush on the 10th busy cycle.
    funct = FMult; operand_a = 32'd3; operand_b = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check("flush pre busy", {63'b0, busy}, 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy drop", {63'b0, busy}, 64'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("flush no done", {63'b0, saw_done}, 64'd0);
    check("flush result held", {result_hi, result_lo}, {32'h00000001, 32'hFFFFFFFD});

    funct = FAddu; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("addu ignored", {62'b0, busy, done}, 64'd0);
    @(posedge clk); #1;
    check("addu still idle", {62'b0, busy, done}, 64'd0);

    // Reset in the 20th cycle of a divide.
    funct = FDiv; operand_a = 32'd1000; operand_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    check("rst pre busy", {63'b0, busy}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid rst outputs", {30'b0, busy, done, result_hi, result_lo}, 64'd0);
    run_op("mult 6*7", FMult, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
